// File: rtl/cpu24_pkg.sv
// Shared widths, control/flag bit positions and buffer states for the 24-bit CPU pipeline.
// Anything that must agree between pipeline stages lives here.
package cpu24_pkg;

    localparam int CPU_DATA_W = 24;
    localparam int CPU_REG_W  = 4;

    localparam int CTL_REGWRITE  = 3;
    localparam int CTL_MEMREAD   = 2;
    localparam int CTL_MEMWRITE  = 1;
    localparam int CTL_FLAGWRITE = 0;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic v, input logic c);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One skid-buffer slot: a valid bit plus payload register with load and clear.
// A cleared slot holds an all-zero payload so downstream sees zeros when idle.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Slot storage; clear wins over load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/exmem_pipe.sv
// EX/MEM pipeline register built as a 2-entry skid buffer with an architectural NZVC register.
// The head slot drives the Out* ports directly; the tail slot absorbs one entry of backpressure.
module exmem_pipe #(
    parameter int DATA_W = cpu24_pkg::CPU_DATA_W,
    parameter int REG_W  = cpu24_pkg::CPU_REG_W
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] Result,
    input  logic              Zero,
    input  logic              Overflow,
    input  logic              CarryOut,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [REG_W-1:0]  Rd,
    input  logic [3:0]        Ctl,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutResult,
    output logic [DATA_W-1:0] OutStoreData,
    output logic [REG_W-1:0]  OutRd,
    output logic [2:0]        OutCtl,
    output logic [3:0]        Flags
);
    import cpu24_pkg::*;

    localparam int PW = 2 * DATA_W + REG_W + 3;

    buf_state_e    r_state;
    buf_state_e    w_next_state;
    logic          r_in_ready;
    logic [3:0]    r_flags;
    logic          w_accept;
    logic          w_release;
    logic          w_head_load, w_head_clear, w_tail_load, w_tail_clear;
    logic          w_head_valid, w_tail_valid;
    logic [PW-1:0] w_in_payload, w_head_din, w_head_data, w_tail_data;

    assign w_in_payload = {Result, StoreData, Rd,
                           Ctl[CTL_REGWRITE], Ctl[CTL_MEMREAD], Ctl[CTL_MEMWRITE]};
    assign w_accept     = InValid & r_in_ready;
    assign w_release    = w_head_valid & OutReady;

    // Next-state and slot steering; flush overrides every handshake.
    always_comb begin
        w_next_state = r_state;
        w_head_load  = 1'b0;
        w_head_clear = 1'b0;
        w_tail_load  = 1'b0;
        w_tail_clear = 1'b0;
        w_head_din   = w_in_payload;
        if (Flush) begin
            w_next_state = EMPTY;
            w_head_clear = 1'b1;
            w_tail_clear = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_head_load  = 1'b1;
                        w_next_state = ONE;
                    end else begin
                        w_next_state = EMPTY;
                    end
                end
                ONE: begin
                    if (w_accept && w_release) begin
                        w_head_load  = 1'b1;
                    end else if (w_accept) begin
                        w_tail_load  = 1'b1;
                        w_next_state = FULL;
                    end else if (w_release) begin
                        w_head_clear = 1'b1;
                        w_next_state = EMPTY;
                    end else begin
                        w_next_state = ONE;
                    end
                end
                FULL: begin
                    // r_in_ready is low here, so only the tail shifts forward.
                    if (w_release) begin
                        w_head_load  = 1'b1;
                        w_head_din   = w_tail_data;
                        w_tail_clear = 1'b1;
                        w_next_state = ONE;
                    end else begin
                        w_next_state = FULL;
                    end
                end
                default: begin
                    w_next_state = EMPTY;
                    w_head_clear = 1'b1;
                    w_tail_clear = 1'b1;
                end
            endcase
        end
    end

    // Buffer state and registered ready; ready stays low through reset.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != FULL);
        end
    end

    // Status flags commit on accept, never on a flushed entry.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_flags <= 4'b0000;
        end else if (!Flush && w_accept && Ctl[CTL_FLAGWRITE]) begin
            r_flags <= pack_flags(Result[DATA_W-1], Zero, Overflow, CarryOut);
        end else begin
            r_flags <= r_flags;
        end
    end

    pipe_slot #(.W(PW)) u_head (
        .i_clk   (Clock),
        .i_rst_n (ResetN),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_data  (w_head_din),
        .o_valid (w_head_valid),
        .o_data  (w_head_data)
    );

    pipe_slot #(.W(PW)) u_tail (
        .i_clk   (Clock),
        .i_rst_n (ResetN),
        .i_load  (w_tail_load),
        .i_clear (w_tail_clear),
        .i_data  (w_in_payload),
        .o_valid (w_tail_valid),
        .o_data  (w_tail_data)
    );

    assign InReady  = r_in_ready;
    assign OutValid = w_head_valid;
    assign Flags    = r_flags;
    assign {OutResult, OutStoreData, OutRd, OutCtl} = w_head_data;

endmodule

// File: tb/tb_exmem_pipe.sv
// Self-checking bench for exmem_pipe: per-feature tasks plus a negedge scoreboard
// that records accepted entries and checks them in order as they are released.
module tb_exmem_pipe;

    localparam int DW = 24;
    localparam int RW = 4;
    localparam int PW = 2 * DW + RW + 3;

    logic          Clock = 1'b0;
    logic          ResetN;
    logic          InValid;
    logic          InReady;
    logic [DW-1:0] Result;
    logic          Zero, Overflow, CarryOut;
    logic [DW-1:0] StoreData;
    logic [RW-1:0] Rd;
    logic [3:0]    Ctl;
    logic          Flush;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutResult;
    logic [DW-1:0] OutStoreData;
    logic [RW-1:0] OutRd;
    logic [2:0]    OutCtl;
    logic [3:0]    Flags;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic [PW-1:0] sb[$];
    logic [PW-1:0] exp_v, got_v;

    exmem_pipe #(.DATA_W(DW), .REG_W(RW)) dut (
        .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .Result(Result), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut),
        .StoreData(StoreData), .Rd(Rd), .Ctl(Ctl), .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
        .OutStoreData(OutStoreData), .OutRd(OutRd), .OutCtl(OutCtl), .Flags(Flags)
    );

    always #5 Clock = ~Clock;

    // Scoreboard: pop and compare on release, then push on accept (models the upcoming edge).
    always @(negedge Clock) begin
        if (!ResetN || Flush) begin
            sb.delete();
        end else begin
            if (OutValid && OutReady) begin
                total++;
                n_out++;
                got_v = {OutResult, OutStoreData, OutRd, OutCtl};
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got %h, expected no output", got_v);
                end else begin
                    exp_v = sb.pop_front();
                    if (got_v !== exp_v) begin
                        bad++;
                        $display("FAIL sb_order: got %h, expected %h", got_v, exp_v);
                    end
                end
            end
            if (InValid && InReady)
                sb.push_back({Result, StoreData, Rd, Ctl[3:1]});
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic op(input logic [DW-1:0] r, input logic z, input logic v, input logic c,
                      input logic [DW-1:0] sd, input logic [RW-1:0] rd, input logic [3:0] ctl);
        InValid   = 1'b1;
        Result    = r;
        Zero      = z;
        Overflow  = v;
        CarryOut  = c;
        StoreData = sd;
        Rd        = rd;
        Ctl       = ctl;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; InValid = 1'b1; Result = 24'h000123; Zero = 1'b1; Overflow = 1'b1;
        CarryOut = 1'b1; StoreData = 24'h000456; Rd = 4'h7; Ctl = 4'b1111;
        Flush = 1'b0; OutReady = 1'b1;
        repeat (3) step();
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL rst_outvalid: got %b, expected 0", OutValid); end
        total++; if (InReady !== 1'b0) begin bad++; $display("FAIL rst_inready: got %b, expected 0", InReady); end
        total++; if ({OutResult, OutStoreData, OutRd, OutCtl} !== {PW{1'b0}}) begin bad++; $display("FAIL rst_fields: got %h, expected 0", {OutResult, OutStoreData, OutRd, OutCtl}); end
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL rst_flags: got %b, expected 0000", Flags); end
        ResetN = 1'b1;
        total++; if (InReady !== 1'b0) begin bad++; $display("FAIL rel_inready_pre: got %b, expected 0", InReady); end
        step();
        total++; if (InReady !== 1'b1) begin bad++; $display("FAIL rel_inready: got %b, expected 1", InReady); end
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL rel_no_accept: got %b, expected 0", OutValid); end
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL rel_flags: got %b, expected 0000", Flags); end
        InValid = 1'b0;
        step();
    endtask

    task automatic test_single();
        OutReady = 1'b1;
        op(24'h000005, 1'b0, 1'b0, 1'b0, 24'h00abcd, 4'h3, 4'b1001);
        step();
        InValid = 1'b0;
        total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b, expected 1", OutValid); end
        total++; if (OutResult !== 24'h000005) begin bad++; $display("FAIL single_result: got %h, expected 000005", OutResult); end
        total++; if (OutCtl !== 3'b100 || OutRd !== 4'h3) begin bad++; $display("FAIL single_ctl_rd: got %b/%h, expected 100/3", OutCtl, OutRd); end
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL single_flags: got %b, expected 0000", Flags); end
        step();
        total++; if (OutValid !== 1'b0 || OutResult !== 24'h000000) begin bad++; $display("FAIL single_idle: got %b/%h, expected 0/000000", OutValid, OutResult); end
    endtask

    task automatic test_flags();
        OutReady = 1'b1;
        op(24'h800000, 1'b0, 1'b1, 1'b0, 24'h000000, 4'h1, 4'b1001);
        step();
        total++; if (Flags !== 4'b1010) begin bad++; $display("FAIL flags_negovf: got %b, expected 1010", Flags); end
        op(24'h000000, 1'b1, 1'b0, 1'b1, 24'h000001, 4'h2, 4'b1000);
        step();
        total++; if (Flags !== 4'b1010) begin bad++; $display("FAIL flags_nowrite: got %b, expected 1010", Flags); end
        op(24'h000001, 1'b1, 1'b0, 1'b1, 24'h000002, 4'h4, 4'b0101);
        step();
        InValid = 1'b0;
        total++; if (Flags !== 4'b0101) begin bad++; $display("FAIL flags_zc: got %b, expected 0101", Flags); end
        step();
        total++; if (Flags !== 4'b0101) begin bad++; $display("FAIL flags_hold: got %b, expected 0101", Flags); end
    endtask

    task automatic test_backpressure();
        int n0;
        n0 = n_out;
        OutReady = 1'b0;
        op(24'h000001, 1'b0, 1'b0, 1'b0, 24'h000011, 4'h1, 4'b1000);
        step();
        total++; if (OutValid !== 1'b1 || OutResult !== 24'h000001 || InReady !== 1'b1) begin bad++; $display("FAIL bp_first: got v=%b r=%h rdy=%b, expected 1/000001/1", OutValid, OutResult, InReady); end
        op(24'h000002, 1'b0, 1'b0, 1'b0, 24'h000022, 4'h2, 4'b0100);
        step();
        total++; if (InReady !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b, expected 0", InReady); end
        total++; if (OutResult !== 24'h000001) begin bad++; $display("FAIL bp_hold1: got %h, expected 000001", OutResult); end
        op(24'h000003, 1'b0, 1'b0, 1'b0, 24'h000033, 4'h3, 4'b0010);
        repeat (2) step();
        total++; if (InReady !== 1'b0 || OutResult !== 24'h000001 || OutStoreData !== 24'h000011) begin bad++; $display("FAIL bp_stall: got rdy=%b r=%h sd=%h, expected 0/000001/000011", InReady, OutResult, OutStoreData); end
        OutReady = 1'b1;
        step();
        total++; if (OutResult !== 24'h000002 || InReady !== 1'b1) begin bad++; $display("FAIL bp_second: got r=%h rdy=%b, expected 000002/1", OutResult, InReady); end
        step();
        InValid = 1'b0;
        total++; if (OutResult !== 24'h000003 || OutValid !== 1'b1) begin bad++; $display("FAIL bp_third: got r=%h v=%b, expected 000003/1", OutResult, OutValid); end
        step();
        total++; if (n_out - n0 !== 3 || OutValid !== 1'b0) begin bad++; $display("FAIL bp_count: got %0d released v=%b, expected 3/0", n_out - n0, OutValid); end
    endtask

    task automatic test_stream();
        int n0;
        int misses;
        n0 = n_out;
        misses = 0;
        OutReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            op(24'h000100 + 24'(i), 1'b0, 1'b0, 1'b0, 24'($urandom), 4'($urandom), {3'($urandom), 1'b0});
            step();
            if (InReady !== 1'b1 || OutValid !== 1'b1 || OutResult !== 24'h000100 + 24'(i)) misses++;
        end
        InValid = 1'b0;
        total++; if (misses !== 0) begin bad++; $display("FAIL stream_cycles: got %0d bad cycles, expected 0", misses); end
        repeat (2) step();
        total++; if (n_out - n0 !== 100) begin bad++; $display("FAIL stream_count: got %0d, expected 100", n_out - n0); end
    endtask

    task automatic test_flush();
        OutReady = 1'b0;
        op(24'h800001, 1'b0, 1'b0, 1'b1, 24'h000aaa, 4'h5, 4'b1001);
        step();
        op(24'h000010, 1'b0, 1'b0, 1'b0, 24'h000bbb, 4'h6, 4'b1000);
        step();
        total++; if (InReady !== 1'b0 || Flags !== 4'b1001) begin bad++; $display("FAIL flush_setup: got rdy=%b flags=%b, expected 0/1001", InReady, Flags); end
        op(24'h7fffff, 1'b1, 1'b1, 1'b1, 24'h000ccc, 4'h7, 4'b1001);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        InValid = 1'b0;
        total++; if (OutValid !== 1'b0 || OutResult !== 24'h000000) begin bad++; $display("FAIL flush_out: got v=%b r=%h, expected 0/000000", OutValid, OutResult); end
        total++; if (InReady !== 1'b1) begin bad++; $display("FAIL flush_empty: got %b, expected 1", InReady); end
        total++; if (Flags !== 4'b1001) begin bad++; $display("FAIL flush_flags: got %b, expected 1001", Flags); end
        OutReady = 1'b1;
        step();
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL flush_gone: got %b, expected 0", OutValid); end
        op(24'h000042, 1'b0, 1'b0, 1'b0, 24'h000ddd, 4'h8, 4'b0100);
        step();
        InValid = 1'b0;
        total++; if (OutValid !== 1'b1 || OutResult !== 24'h000042) begin bad++; $display("FAIL flush_after: got v=%b r=%h, expected 1/000042", OutValid, OutResult); end
        step();
    endtask

    task automatic test_async_reset();
        OutReady = 1'b0;
        op(24'h800000, 1'b0, 1'b1, 1'b1, 24'h000eee, 4'h9, 4'b1011);
        step();
        op(24'h000077, 1'b0, 1'b0, 1'b0, 24'h000fff, 4'ha, 4'b1000);
        step();
        total++; if (Flags !== 4'b1011 || OutValid !== 1'b1) begin bad++; $display("FAIL areset_setup: got flags=%b v=%b, expected 1011/1", Flags, OutValid); end
        #2;
        ResetN = 1'b0;
        #1;
        total++; if (OutValid !== 1'b0 || InReady !== 1'b0) begin bad++; $display("FAIL areset_ctrl: got v=%b rdy=%b, expected 0/0", OutValid, InReady); end
        total++; if ({OutResult, OutStoreData, OutRd, OutCtl} !== {PW{1'b0}}) begin bad++; $display("FAIL areset_fields: got %h, expected 0", {OutResult, OutStoreData, OutRd, OutCtl}); end
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL areset_flags: got %b, expected 0000", Flags); end
        InValid = 1'b0;
        OutReady = 1'b1;
        step();
        ResetN = 1'b1;
        step();
        total++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin bad++; $display("FAIL areset_rel: got rdy=%b v=%b, expected 1/0", InReady, OutValid); end
        op(24'h000abc, 1'b0, 1'b0, 1'b0, 24'h000123, 4'hb, 4'b0010);
        step();
        InValid = 1'b0;
        total++; if (OutValid !== 1'b1 || OutResult !== 24'h000abc) begin bad++; $display("FAIL areset_resume: got v=%b r=%h, expected 1/000abc", OutValid, OutResult); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_backpressure();
        test_stream();
        test_flush();
        test_async_reset();
        step();
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_drain: got %0d pending, expected 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
